// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned WEN_W  = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RESP
   } arb_state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } arb_owner_t;

   // Streak counter must hold 0..max inclusive; never narrower than one bit.
   function automatic int unsigned dstreak_width(input int unsigned max_streak);
      return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Single-outstanding memory bus: request/address phase plus response phase.
interface mem_bus_arbiter_if;
   import mem_bus_arbiter_pkg::*;

   logic              bus_req;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [WEN_W-1:0]  bus_wen;
   logic              bus_gnt;
   logic              bus_rvalid;
   logic [DATA_W-1:0] bus_rdata;

   modport master (
      output bus_req, bus_addr, bus_wdata, bus_wen,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_addr, bus_wdata, bus_wen,
      output bus_gnt, bus_rvalid, bus_rdata
   );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one memory bus,
// data-first with a bounded data streak so fetches cannot starve.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_DSTREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              imem_ena,
   input  logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_cancel,
   output logic [DATA_W-1:0] imem_dout,
   output logic              imem_ready,
   input  logic              dmem_ena,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [DATA_W-1:0] dmem_din,
   input  logic [WEN_W-1:0]  dmem_wen,
   output logic [DATA_W-1:0] dmem_dout,
   output logic              dmem_ready,
   mem_bus_arbiter_if.master bus
);

   localparam int unsigned    DS_W   = dstreak_width(MAX_DSTREAK);
   localparam logic [DS_W-1:0] DS_MAX = DS_W'(MAX_DSTREAK);

   arb_state_t        state_q;
   arb_owner_t        owner_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [WEN_W-1:0]  wen_q;
   logic              bus_req_q;
   logic [DS_W-1:0]   dstreak_q;
   logic              cancel_q;
   logic [DATA_W-1:0] imem_dout_q;
   logic [DATA_W-1:0] dmem_dout_q;

   logic i_req;
   logic grant_d;
   logic grant_i;
   logic deliver;

   always_comb begin
      // A cancelled fetch in IDLE is not a candidate at all.
      i_req   = imem_ena & ~imem_cancel;
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (state_q == S_IDLE) begin
         grant_d = dmem_ena & ~(i_req & (dstreak_q == DS_MAX));
         grant_i = i_req & ~grant_d;
      end
      deliver    = (state_q == S_RESP) & bus.bus_rvalid;
      imem_ready = deliver & (owner_q == OWN_I) & ~cancel_q & ~imem_cancel;
      dmem_ready = deliver & (owner_q == OWN_D);
      imem_dout  = imem_ready ? bus.bus_rdata : imem_dout_q;
      dmem_dout  = dmem_ready ? bus.bus_rdata : dmem_dout_q;
   end

   assign bus.bus_req   = bus_req_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_wen   = wen_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_I;
         addr_q      <= '0;
         wdata_q     <= '0;
         wen_q       <= '0;
         bus_req_q   <= 1'b0;
         dstreak_q   <= '0;
         cancel_q    <= 1'b0;
         imem_dout_q <= '0;
         dmem_dout_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_d) begin
                  owner_q   <= OWN_D;
                  addr_q    <= dmem_addr;
                  wdata_q   <= dmem_din;
                  wen_q     <= dmem_wen;
                  bus_req_q <= 1'b1;
                  state_q   <= S_REQ;
                  if (imem_ena && (dstreak_q != DS_MAX))
                     dstreak_q <= dstreak_q + DS_W'(1);
               end else if (grant_i) begin
                  owner_q   <= OWN_I;
                  addr_q    <= imem_addr;
                  wdata_q   <= '0;
                  wen_q     <= '0;
                  bus_req_q <= 1'b1;
                  state_q   <= S_REQ;
                  dstreak_q <= '0;
                  cancel_q  <= 1'b0;
               end
            end
            S_REQ: begin
               if ((owner_q == OWN_I) && imem_cancel)
                  cancel_q <= 1'b1;
               if (bus.bus_gnt) begin
                  bus_req_q <= 1'b0;
                  state_q   <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.bus_rvalid) begin
                  state_q  <= S_IDLE;
                  cancel_q <= 1'b0;
                  if (imem_ready)
                     imem_dout_q <= bus.bus_rdata;
                  if (dmem_ready)
                     dmem_dout_q <= bus.bus_rdata;
               end else if ((owner_q == OWN_I) && imem_cancel) begin
                  cancel_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               bus_req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
